shift_pipe_dual: RTL

//  Parametrised successor to the 2-bit dual-output register exercise: a WIDTH-bit,

---
 rtl/shift_pipe_dual_pkg.sv | 8 +
 rtl/shift_pipe_dual_stage.sv | 38 +++
 rtl/shift_pipe_dual.sv | 75 +++++++
 3 files changed

// File: rtl/shift_pipe_dual_pkg.sv
// Default geometry shared by lab top-levels that instantiate shift_pipe_dual.
package shift_pipe_dual_pkg;

   localparam int unsigned DEF_WIDTH = 2;
   localparam int unsigned DEF_DEPTH = 4;
   localparam int unsigned DEF_TAP   = 1;

endpackage : shift_pipe_dual_pkg

// File: rtl/shift_pipe_dual_stage.sv
// One pipeline register: async active-low reset, synchronous flush, enable.
module shift_pipe_stage
   import shift_pipe_dual_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   // Flush beats enable; otherwise hold.
   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = '0;
      end else if (en) begin
         q_d = d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule : shift_pipe_stage

// File: rtl/shift_pipe_dual.sv
// Enable-gated WIDTH x DEPTH shift pipeline with a final-stage output y, an
// intermediate tap z, and fill-count-driven valid flags for each.
module shift_pipe_dual
   import shift_pipe_dual_pkg::*;
#(
   parameter  int unsigned WIDTH = DEF_WIDTH,
   parameter  int unsigned DEPTH = DEF_DEPTH,
   parameter  int unsigned TAP   = DEF_TAP,
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] z,
   output logic             y_valid,
   output logic             z_valid,
   output logic [CW-1:0]    fill_cnt
);

   generate
      if (WIDTH < 1 || DEPTH < 1 || TAP < 1 || TAP > DEPTH) begin : g_bad_params
         $error("shift_pipe_dual: illegal WIDTH/DEPTH/TAP combination");
      end
   endgenerate

   // stg[0] is the input; stg[k] is the output of stage k.
   logic [WIDTH-1:0] stg [DEPTH+1];

   assign stg[0] = din;

   for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
      shift_pipe_stage #(
         .WIDTH (WIDTH)
      ) u_stage (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (en),
         .clr   (clr),
         .d     (stg[k-1]),
         .q     (stg[k])
      );
   end

   assign y = stg[DEPTH];
   assign z = stg[TAP];

   logic [CW-1:0] fill_q;
   logic [CW-1:0] fill_d;

   // Counts accepted samples and stops at DEPTH so the valids never drop on wrap.
   always_comb begin
      fill_d = fill_q;
      if (clr) begin
         fill_d = '0;
      end else if (en && (fill_q != CW'(DEPTH))) begin
         fill_d = fill_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill_q <= '0;
      end else begin
         fill_q <= fill_d;
      end
   end

   assign fill_cnt = fill_q;
   assign y_valid  = (fill_q == CW'(DEPTH));
   assign z_valid  = (fill_q >= CW'(TAP));

endmodule : shift_pipe_dual
